// File: rtl/mult_share_arb.sv
// -----------------------------------------------------------------------------
// mult_share_arb
//
// Time-shares one external 8x8 signed Booth multiplier among N_REQ requesters.
// One operand pair is accepted at a time and the multiplier is pulsed to start.
// The controller then counts the 8 multiply steps, captures the 16-bit product
// and returns it, tagged with the owning requester ID, on a valid/ready channel.
//
// Ports:
//   clk, rst_n           clock (shared with multiplier), async active-low reset
//   req[N_REQ]           per-requester request, operands held until granted
//   a_in, b_in           packed operands, requester i uses bits [8i+7:8i]
//   gnt[N_REQ]           one-hot grant, combinational, high in the accept cycle
//   rsp_valid/rsp_ready  response handshake
//   rsp_id, rsp_prod     owner index and signed product of the response
//   mult_start           one-cycle start pulse to the multiplier
//   mult_multiplicand    registered operand A to the multiplier
//   mult_multiplier      registered operand B to the multiplier
//   mult_prod, mult_busy product and busy flag from the multiplier
//   err                  sticky: multiplier still busy at capture time
//
// Build option:
//   MULT_ARB_FIXED_PRIO_EN  defined   -> fixed priority, lowest index wins
//                           undefined -> round-robin (default)
// -----------------------------------------------------------------------------
module mult_share_arb #(
    parameter int N_REQ = 4,
    parameter int ID_W  = 2
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [N_REQ-1:0]   req,
    input  logic [N_REQ*8-1:0] a_in,
    input  logic [N_REQ*8-1:0] b_in,
    output logic [N_REQ-1:0]   gnt,
    output logic               rsp_valid,
    input  logic               rsp_ready,
    output logic [ID_W-1:0]    rsp_id,
    output logic [15:0]        rsp_prod,
    output logic               mult_start,
    output logic [7:0]         mult_multiplicand,
    output logic [7:0]         mult_multiplier,
    input  logic [15:0]        mult_prod,
    input  logic               mult_busy,
    output logic               err
);

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_START = 3'd1,
        ST_WAIT  = 3'd2,
        ST_CAPT  = 3'd3,
        ST_RESP  = 3'd4
    } state_t;

    state_t          r_state;
    state_t          w_next;
    logic [ID_W-1:0] r_id;
    logic [ID_W-1:0] r_rsp_id;
    logic [ID_W-1:0] w_winner;
    logic [ID_W-1:0] w_idx;
    logic            w_any;
    logic            w_accept;
    logic [N_REQ-1:0] w_gnt;
    logic [ID_W+2:0] w_lane;
    logic [2:0]      r_cnt;
    logic            r_start;
    logic            r_valid;
    logic            r_err;
    logic [7:0]      r_a;
    logic [7:0]      r_b;
    logic [15:0]     r_prod;

`ifdef MULT_ARB_FIXED_PRIO_EN
    // Winner select: fixed priority; scanning downward leaves the lowest set index.
    always_comb begin
        w_any    = 1'b0;
        w_winner = '0;
        w_idx    = '0;
        for (int i = N_REQ - 1; i >= 0; i--) begin
            w_idx    = ID_W'(i);
            w_winner = req[w_idx] ? w_idx : w_winner;
            w_any    = w_any | req[w_idx];
        end
    end
`else
    logic [ID_W-1:0] r_ptr;

    // Winner select: round-robin starting just after the last winner; scanning
    // the offsets downward leaves the nearest requester after the pointer.
    always_comb begin
        w_any    = 1'b0;
        w_winner = '0;
        w_idx    = '0;
        for (int k = N_REQ; k >= 1; k--) begin
            w_idx    = ID_W'((int'(r_ptr) + k) % N_REQ);
            w_winner = req[w_idx] ? w_idx : w_winner;
            w_any    = w_any | req[w_idx];
        end
    end

    // Round-robin pointer: reset to the last index so requester 0 is favoured first.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ptr <= ID_W'(N_REQ - 1);
        end else if (w_accept) begin
            r_ptr <= w_winner;
        end else begin
            r_ptr <= r_ptr;
        end
    end
`endif

    // Operand accept condition and byte offset of the winner's operands.
    always_comb begin
        w_accept = (r_state == ST_IDLE) && w_any;
        w_lane   = {w_winner, 3'b000};
    end

    // Next-state decode and combinational grant (only ever asserted in IDLE).
    always_comb begin
        w_next = r_state;
        w_gnt  = '0;
        case (r_state)
            ST_IDLE: begin
                if (w_any) begin
                    w_next          = ST_START;
                    // Gated by rst_n so outputs read zero while reset is held.
                    w_gnt[w_winner] = rst_n;
                end else begin
                    w_next = ST_IDLE;
                end
            end
            ST_START: begin
                w_next = ST_WAIT;
            end
            ST_WAIT: begin
                // Counter value 7 marks the 8th step edge: product final after it.
                if (r_cnt == 3'd7) begin
                    w_next = ST_CAPT;
                end else begin
                    w_next = ST_WAIT;
                end
            end
            ST_CAPT: begin
                w_next = ST_RESP;
            end
            ST_RESP: begin
                if (rsp_ready) begin
                    w_next = ST_IDLE;
                end else begin
                    w_next = ST_RESP;
                end
            end
            default: begin
                w_next = ST_IDLE;
            end
        endcase
    end

    // State register plus registered start/valid flags derived from the next state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
            r_start <= 1'b0;
            r_valid <= 1'b0;
        end else begin
            r_state <= w_next;
            r_start <= (w_next == ST_START);
            r_valid <= (w_next == ST_RESP);
        end
    end

    // Operand and owner latch at the accept edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_a  <= 8'h00;
            r_b  <= 8'h00;
            r_id <= '0;
        end else if (w_accept) begin
            r_a  <= a_in[w_lane +: 8];
            r_b  <= b_in[w_lane +: 8];
            r_id <= w_winner;
        end else begin
            r_a  <= r_a;
            r_b  <= r_b;
            r_id <= r_id;
        end
    end

    // Multiply step counter: cleared in START, advanced on every WAIT edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt <= 3'd0;
        end else if (r_state == ST_START) begin
            r_cnt <= 3'd0;
        end else if (r_state == ST_WAIT) begin
            r_cnt <= r_cnt + 3'd1;
        end else begin
            r_cnt <= r_cnt;
        end
    end

    // Product capture: mult_prod is only valid in CAPT since the multiplier keeps stepping.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_prod   <= 16'h0000;
            r_rsp_id <= '0;
            r_err    <= 1'b0;
        end else if (r_state == ST_CAPT) begin
            r_prod   <= mult_prod;
            r_rsp_id <= r_id;
            r_err    <= r_err | mult_busy;
        end else begin
            r_prod   <= r_prod;
            r_rsp_id <= r_rsp_id;
            r_err    <= r_err;
        end
    end

    assign gnt               = w_gnt;
    assign rsp_valid         = r_valid;
    assign rsp_id            = r_rsp_id;
    assign rsp_prod          = r_prod;
    assign mult_start        = r_start;
    assign mult_multiplicand = r_a;
    assign mult_multiplier   = r_b;
    assign err               = r_err;

endmodule

// File: tb/tb_mult_share_arb.sv
// -----------------------------------------------------------------------------
// tb_mult_share_arb
//
// Self-checking bench for mult_share_arb. Contains a behavioural model of the
// external multiplier whose product is correct only in the capture cycle, a
// negedge monitor with a scoreboard queue, a vector table and a few sequences.
// -----------------------------------------------------------------------------
module tb_mult_share_arb;

    localparam int N_REQ = 4;
    localparam int ID_W  = 2;

    logic               clk       = 1'b0;
    logic               rst_n     = 1'b0;
    logic [N_REQ-1:0]   req       = '0;
    logic [N_REQ*8-1:0] a_in      = '0;
    logic [N_REQ*8-1:0] b_in      = '0;
    logic               rsp_ready = 1'b1;
    logic [N_REQ-1:0]   gnt;
    logic               rsp_valid;
    logic [ID_W-1:0]    rsp_id;
    logic [15:0]        rsp_prod;
    logic               mult_start;
    logic [7:0]         mult_multiplicand;
    logic [7:0]         mult_multiplier;
    logic [15:0]        mult_prod;
    logic               mult_busy;
    logic               err;

    int n_tests = 0;
    int n_fail  = 0;

    mult_share_arb #(.N_REQ(N_REQ), .ID_W(ID_W)) dut (
        .clk               (clk),
        .rst_n             (rst_n),
        .req               (req),
        .a_in              (a_in),
        .b_in              (b_in),
        .gnt               (gnt),
        .rsp_valid         (rsp_valid),
        .rsp_ready         (rsp_ready),
        .rsp_id            (rsp_id),
        .rsp_prod          (rsp_prod),
        .mult_start        (mult_start),
        .mult_multiplicand (mult_multiplicand),
        .mult_multiplier   (mult_multiplier),
        .mult_prod         (mult_prod),
        .mult_busy         (mult_busy),
        .err               (err)
    );

    always #5 clk = ~clk;

    // Multiplier model: 8 steps after the start edge, then keeps counting and
    // wrapping; the product is only correct when the step count is exactly 8.
    logic signed [15:0] m_prod = 16'sd0;
    logic [3:0]         m_cnt  = 4'd9;
    logic               m_run  = 1'b0;
    logic               m_busy_force = 1'b0;

    always @(posedge clk) begin
        if (mult_start) begin
            m_prod <= $signed(mult_multiplicand) * $signed(mult_multiplier);
            m_cnt  <= 4'd0;
            m_run  <= 1'b1;
        end else begin
            m_cnt <= m_cnt + 4'd1;
            if (m_cnt == 4'd7) m_run <= 1'b0;
        end
    end

    assign mult_prod = (m_cnt == 4'd8) ? m_prod : (m_prod ^ 16'hA5C3);
    assign mult_busy = m_run | m_busy_force;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic fail_bound(input string name);
        n_tests++;
        n_fail++;
        $display("FAIL %s: bound expired, awaited event not seen", name);
    endtask

    function automatic int pick(input logic [N_REQ-1:0] r, input int ptr);
`ifdef MULT_ARB_FIXED_PRIO_EN
        for (int i = 0; i < N_REQ; i++) if (r[i]) return i;
`else
        for (int k = 1; k <= N_REQ; k++) if (r[(ptr + k) % N_REQ]) return (ptr + k) % N_REQ;
`endif
        return -1;
    endfunction

    // Scoreboard and monitor state
    typedef struct {
        int          id;
        logic [15:0] prod;
        int          cyc;
    } exp_t;

    exp_t             exp_q[$];
    int               gnt_ids[$];
    int               gnt_cycs[$];
    int               cyc        = 0;
    int               mdl_ptr    = N_REQ - 1;
    int               n_vld_rise = 0;
    logic [N_REQ-1:0] prev_gnt   = '0;
    bit               prev_vld   = 1'b0;
    bit               prev_hs    = 1'b0;
    logic [15:0]      prev_prod  = '0;
    logic [ID_W-1:0]  prev_id    = '0;
    int               m_e;
    int               m_g;
    logic [N_REQ-1:0] m_exp_gnt;
    logic signed [7:0]  m_sa;
    logic signed [7:0]  m_sb;
    exp_t             m_ent;

    always @(negedge clk) begin
        cyc++;
        if (!rst_n) begin
            exp_q.delete();
            mdl_ptr  = N_REQ - 1;
            prev_gnt = '0;
            prev_vld = 1'b0;
            prev_hs  = 1'b0;
        end else begin
            check("mult_start_pulse", mult_start, prev_gnt != '0);
            if (gnt != '0) begin
                m_e = pick(req, mdl_ptr);
                m_exp_gnt = '0;
                if (m_e >= 0) m_exp_gnt[m_e] = 1'b1;
                check("gnt_winner", gnt, m_exp_gnt);
                m_g = -1;
                for (int i = 0; i < N_REQ; i++) if (gnt[i]) m_g = i;
                gnt_ids.push_back(m_g);
                gnt_cycs.push_back(cyc);
                if (m_e >= 0) begin
                    m_sa       = a_in[8*m_e +: 8];
                    m_sb       = b_in[8*m_e +: 8];
                    m_ent.id   = m_e;
                    m_ent.prod = m_sa * m_sb;
                    m_ent.cyc  = cyc;
                    exp_q.push_back(m_ent);
                    mdl_ptr = m_e;
                end
            end
            if (prev_hs) check("valid_drop", rsp_valid, 1'b0);
            if (rsp_valid) begin
                check("gnt_in_resp", gnt, '0);
                if (!prev_vld) begin
                    n_vld_rise++;
                    if (exp_q.size() == 0) begin
                        n_tests++;
                        n_fail++;
                        $display("FAIL unexpected_rsp: got id %0d prod 0x%0h, expected no response", rsp_id, rsp_prod);
                    end else begin
                        check("sb_id", rsp_id, exp_q[0].id);
                        check("sb_prod", rsp_prod, exp_q[0].prod);
                        check("sb_latency", cyc - exp_q[0].cyc, 11);
                    end
                end else if (!prev_hs) begin
                    check("hold_prod", rsp_prod, prev_prod);
                    check("hold_id", rsp_id, prev_id);
                end
                if (rsp_ready && exp_q.size() != 0) void'(exp_q.pop_front());
            end
            prev_gnt  = gnt;
            prev_vld  = rsp_valid;
            prev_hs   = rsp_valid && rsp_ready;
            prev_prod = rsp_prod;
            prev_id   = rsp_id;
        end
    end

    // Waits for any grant; returns its index just after the accepting edge.
    task automatic wait_gnt(output int id);
        id = -1;
        for (int c = 0; c < 100; c++) begin
            @(negedge clk);
            if (gnt != '0) begin
                for (int i = 0; i < N_REQ; i++) if (gnt[i]) id = i;
                break;
            end
        end
        if (id < 0) fail_bound("wait_gnt");
        @(posedge clk);
        #1;
    endtask

    // Waits (at a negedge) for rsp_valid.
    task automatic wait_vld(output bit ok);
        ok = 1'b0;
        for (int c = 0; c < 40; c++) begin
            @(negedge clk);
            if (rsp_valid) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) fail_bound("wait_vld");
    endtask

    // Waits until every expected response has been returned.
    task automatic drain();
        bit done;
        done = 1'b0;
        for (int c = 0; c < 80; c++) begin
            @(posedge clk);
            if (exp_q.size() == 0 && !rsp_valid) begin
                done = 1'b1;
                break;
            end
        end
        if (!done) fail_bound("drain");
        #1;
    endtask

    typedef struct {
        int          id;
        logic [7:0]  a;
        logic [7:0]  b;
        logic [15:0] exp;
    } vec_t;

    vec_t vecs[8];
    int   rr_exp[5];

    initial begin
        int g;
        bit ok;
        int rise0;

        vecs[0] = '{0, 8'h03, 8'h05, 16'h000F};
        vecs[1] = '{2, 8'hFD, 8'h07, 16'hFFEB};
        vecs[2] = '{3, 8'h00, 8'hFF, 16'h0000};
        vecs[3] = '{1, 8'h7F, 8'h80, 16'hC080};
        vecs[4] = '{0, 8'h7F, 8'h7F, 16'h3F01};
        vecs[5] = '{2, 8'hFF, 8'hFF, 16'h0001};
        vecs[6] = '{3, 8'h81, 8'h7F, 16'hC0FF};
        vecs[7] = '{1, 8'h0A, 8'hF6, 16'hFF9C};
`ifdef MULT_ARB_FIXED_PRIO_EN
        rr_exp = '{0, 0, 0, 0, 0};
`else
        rr_exp = '{0, 1, 2, 3, 0};
`endif

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        check("reset_outputs",
              {gnt, rsp_valid, rsp_id, rsp_prod, mult_start, mult_multiplicand, mult_multiplier, err}, '0);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Round-robin with all requests held
        gnt_ids.delete();
        gnt_cycs.delete();
        for (int i = 0; i < N_REQ; i++) begin
            a_in[8*i +: 8] = 8'(i * 17 + 3);
            b_in[8*i +: 8] = 8'(-(i + 2));
        end
        req = 4'b1111;
        for (int c = 0; c < 120; c++) begin
            @(posedge clk);
            if (gnt_ids.size() >= 5) break;
        end
        #1;
        req = '0;
        if (gnt_ids.size() >= 5) begin
            for (int k = 0; k < 5; k++) check("rr_order", gnt_ids[k], rr_exp[k]);
            for (int k = 1; k < 5; k++) check("rr_spacing", gnt_cycs[k] - gnt_cycs[k-1], 12);
        end else begin
            fail_bound("rr_grants");
        end
        drain();

        // Vector table, single requests back to back
        for (int v = 0; v < 8; v++) begin
            a_in[8*vecs[v].id +: 8] = vecs[v].a;
            b_in[8*vecs[v].id +: 8] = vecs[v].b;
            req[vecs[v].id] = 1'b1;
            wait_gnt(g);
            check("tbl_gnt_id", g, vecs[v].id);
            req = '0;
            wait_vld(ok);
            if (ok) begin
                check("tbl_prod", rsp_prod, vecs[v].exp);
                check("tbl_id", rsp_id, vecs[v].id);
                check("tbl_err", err, 1'b0);
            end
            @(posedge clk);
            #1;
        end

        // Backpressure: response held while rsp_ready is low; pending req waits
        rsp_ready = 1'b0;
        a_in[15:8] = 8'h12;
        b_in[15:8] = 8'h34;
        a_in[23:16] = 8'h05;
        b_in[23:16] = 8'h06;
        req[1] = 1'b1;
        wait_gnt(g);
        check("bp_gnt_id", g, 1);
        req = '0;
        wait_vld(ok);
        req[2] = 1'b1;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            check("bp_valid", rsp_valid, 1'b1);
            check("bp_prod", rsp_prod, 16'h03A8);
            check("bp_id", rsp_id, 2'd1);
            check("bp_no_gnt", gnt, '0);
        end
        @(posedge clk);
        #1;
        rsp_ready = 1'b1;
        @(negedge clk);
        check("bp_hs_valid", rsp_valid, 1'b1);
        check("bp_hs_no_gnt", gnt, '0);
        @(negedge clk);
        check("bp_after_valid", rsp_valid, 1'b0);
        check("bp_pending_gnt", gnt, 4'b0100);
        @(posedge clk);
        #1;
        req = '0;
        drain();

        // Multiplier busy at capture sets the sticky error
        m_busy_force = 1'b1;
        a_in[7:0] = 8'h02;
        b_in[7:0] = 8'h03;
        req[0] = 1'b1;
        wait_gnt(g);
        req = '0;
        wait_vld(ok);
        check("err_set", err, 1'b1);
        @(posedge clk);
        #1;
        m_busy_force = 1'b0;
        req[0] = 1'b1;
        wait_gnt(g);
        req = '0;
        wait_vld(ok);
        check("err_sticky", err, 1'b1);
        @(posedge clk);
        #1;

        // Reset during WAIT: outputs clear at once and no response follows
        a_in[23:16] = 8'h11;
        b_in[23:16] = 8'h22;
        req[2] = 1'b1;
        wait_gnt(g);
        req = '0;
        repeat (4) @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        check("midop_reset_outputs",
              {gnt, rsp_valid, rsp_id, rsp_prod, mult_start, mult_multiplicand, mult_multiplier, err}, '0);
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        rise0 = n_vld_rise;
        repeat (20) @(posedge clk);
        #1;
        check("no_rsp_after_reset", n_vld_rise, rise0);

        // Pointer restarts after reset: requester 1 wins over 3
        a_in[15:8]  = 8'h7F;
        b_in[15:8]  = 8'h80;
        a_in[31:24] = 8'h09;
        b_in[31:24] = 8'h09;
        req = 4'b1010;
        wait_gnt(g);
        check("post_reset_first_gnt", g, 1);
        req[1] = 1'b0;
        wait_vld(ok);
        if (ok) check("post_reset_prod", rsp_prod, 16'hC080);
        wait_gnt(g);
        check("post_reset_second_gnt", g, 3);
        req = '0;
        drain();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

endmodule
